pll_phase_shift: RTL and testbench

- Converts the single-cycle pll_ph_inc/pll_ph_dec requests from the delay-adjust loop into MMCM dynamic phase-shift transactions using the PSEN/PSINCDEC/PSDONE handshake.
- Each request becomes a burst of STEPS_PER_REQ fine steps.
- Queues net pending requests, tracks the accumulated phase position, and flags handshake timeouts and queue overflow.
- Sits between adjust_m and the dc MMCM, in the MMCM PSCLK domain. CDC of the request pulses is the instantiating level's job.

---
 rtl/pll_ps_pkg.sv | 22 ++
 rtl/pll_phase_shift.sv | 173 +++++++++++++++++
 tb/tb_pll_phase_shift.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_ps_pkg.sv
// Shared types for the MMCM dynamic phase-shift sequencer.
package pll_ps_pkg;

  // Sequencer states: wait for work, issue one PSEN, wait for PSDONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } ps_state_e;

  // Default width of the signed net pending-request counter.
  localparam int PEND_WIDTH_DFLT = 4;

  typedef logic signed [PEND_WIDTH_DFLT-1:0] pend_t;

  // Direction of a fine-step burst; the encoding matches PSINCDEC.
  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

endpackage

// File: rtl/pll_phase_shift.sv
// Turns single-cycle phase inc/dec requests into bursts of MMCM dynamic
// phase-shift steps over the PSEN/PSINCDEC/PSDONE handshake. Net pending
// requests are queued in a saturating signed counter; the completed step
// position, handshake timeouts and queue overflow are reported.
module pll_phase_shift
  import pll_ps_pkg::*;
#(
  parameter int STEPS_PER_REQ = 8,
  parameter int PEND_WIDTH    = $bits(pend_t),
  parameter int TIMEOUT       = 64,
  parameter int POS_WIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ph_inc,
  input  logic                        ph_dec,
  output logic                        psen,
  output logic                        psincdec,
  input  logic                        psdone,
  output logic                        busy,
  output logic signed [POS_WIDTH-1:0] pos,
  output logic                        err_timeout,
  output logic                        err_ovf,
  input  logic                        err_clr
);

  localparam int STEP_W = $clog2(STEPS_PER_REQ + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);
  localparam int PX_W   = PEND_WIDTH + 2;

  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEPS_PER_REQ);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  // Pending-counter limits in a widened signed domain so that the
  // unsaturated sum can be compared without wrapping.
  localparam logic signed [PX_W-1:0] PEND_MAX_X = PX_W'(2**(PEND_WIDTH-1) - 1);
  localparam logic signed [PX_W-1:0] PEND_MIN_X = -PEND_MAX_X - PX_W'(1);

  ps_state_e                      state_q, state_d;
  dir_e                           dir_q, dir_d;
  logic [STEP_W-1:0]              step_cnt_q, step_cnt_d;
  logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
  logic signed [PEND_WIDTH-1:0]   pending_q, pending_d;
  logic signed [POS_WIDTH-1:0]    pos_q, pos_d;
  logic                           psen_q, psen_d;
  logic                           psincdec_q, psincdec_d;
  logic                           err_timeout_q, err_timeout_d;
  logic                           err_ovf_q, err_ovf_d;

  logic signed [1:0]              disp;
  logic                           tmo_hit;
  logic [PEND_WIDTH:0]            pend_nxt;

  // Next pending value: remove the dispatched burst first, then apply the
  // net request. A request that would leave the signed range is dropped
  // and reported in the MSB of the result; the dispatch still applies.
  function automatic logic [PEND_WIDTH:0] pend_sat_step(
    input logic signed [PEND_WIDTH-1:0] cur,
    input logic                         inc,
    input logic                         dec,
    input logic signed [1:0]            dsp
  );
    logic signed [PX_W-1:0] base;
    logic signed [PX_W-1:0] req;
    logic signed [PX_W-1:0] sum;
    logic                   ovf;
    base = PX_W'(cur) - PX_W'(dsp);
    req  = '0;
    if (inc && !dec) begin
      req = PX_W'(1);
    end else if (dec && !inc) begin
      req = '1;
    end
    sum = base + req;
    ovf = (sum > PEND_MAX_X) || (sum < PEND_MIN_X);
    if (ovf) begin
      sum = base;
    end
    return {ovf, sum[PEND_WIDTH-1:0]};
  endfunction

  // Sequencer: dispatch from the queue, pulse PSEN, then wait for PSDONE
  // or give up after TIMEOUT cycles counted from the PSEN cycle.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    pos_d      = pos_q;
    disp       = 2'sb00;
    tmo_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        // A latched timeout freezes dispatch until software clears it.
        if ((pending_q != '0) && !err_timeout_q) begin
          dir_d      = pending_q[PEND_WIDTH-1] ? DIR_DEC : DIR_INC;
          disp       = pending_q[PEND_WIDTH-1] ? 2'sb11 : 2'sb01;
          step_cnt_d = STEP_LOAD;
          tmo_cnt_d  = '0;
          state_d    = PULSE;
        end
      end
      PULSE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        // PSDONE on the last allowed cycle still counts as completion.
        if (psdone) begin
          pos_d      = (dir_q == DIR_INC) ? pos_q + POS_WIDTH'(1)
                                          : pos_q - POS_WIDTH'(1);
          step_cnt_d = step_cnt_q - STEP_W'(1);
          tmo_cnt_d  = '0;
          state_d    = (step_cnt_q == STEP_W'(1)) ? IDLE : PULSE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit    = 1'b1;
          step_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    psen_d     = (state_d == PULSE);
    psincdec_d = (state_d == PULSE) && (dir_d == DIR_INC);
  end

  // Request queue and sticky error flags; a new error beats a clear.
  always_comb begin
    pend_nxt      = pend_sat_step(pending_q, ph_inc, ph_dec, disp);
    pending_d     = pend_nxt[PEND_WIDTH-1:0];
    err_ovf_d     = pend_nxt[PEND_WIDTH] || (err_ovf_q && !err_clr);
    err_timeout_d = tmo_hit || (err_timeout_q && !err_clr);
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dir_q         <= DIR_DEC;
      step_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      pending_q     <= '0;
      pos_q         <= '0;
      psen_q        <= 1'b0;
      psincdec_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      step_cnt_q    <= step_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      pending_q     <= pending_d;
      pos_q         <= pos_d;
      psen_q        <= psen_d;
      psincdec_q    <= psincdec_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign psen        = psen_q;
  assign psincdec    = psincdec_q;
  assign pos         = pos_q;
  assign err_timeout = err_timeout_q;
  assign err_ovf     = err_ovf_q;
  assign busy        = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_pll_phase_shift.sv
// Directed bench for pll_phase_shift with a PSDONE responder model.
module tb_pll_phase_shift;

  localparam int STEPS = 8;
  localparam int PEND_W = 4;
  localparam int TMO = 64;
  localparam int POS_W = 16;
  localparam int LAT = 12;

  logic                    clk;
  logic                    rst;
  logic                    ph_inc;
  logic                    ph_dec;
  logic                    psen;
  logic                    psincdec;
  logic                    psdone;
  logic                    busy;
  logic signed [POS_W-1:0] pos;
  logic                    err_timeout;
  logic                    err_ovf;
  logic                    err_clr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit resp_en = 1'b1;
  int resp_lat = LAT;

  pll_phase_shift #(
    .STEPS_PER_REQ(STEPS),
    .PEND_WIDTH   (PEND_W),
    .TIMEOUT      (TMO),
    .POS_WIDTH    (POS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ph_inc     (ph_inc),
    .ph_dec     (ph_dec),
    .psen       (psen),
    .psincdec   (psincdec),
    .psdone     (psdone),
    .busy       (busy),
    .pos        (pos),
    .err_timeout(err_timeout),
    .err_ovf    (err_ovf),
    .err_clr    (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // MMCM model: PSDONE pulses resp_lat cycles after a PSEN cycle.
  initial begin
    int cnt;
    cnt = 0;
    psdone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      psdone = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) psdone = 1'b1;
      end
      if (psen === 1'b1 && resp_en) cnt = resp_lat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (psen !== 1'b0) begin miscompares++; $display("FAIL reset_psen: got %b, expected 0", psen); end
    vectors++; if (psincdec !== 1'b0) begin miscompares++; $display("FAIL reset_psincdec: got %b, expected 0", psincdec); end
    vectors++; if (pos !== 16'sd0) begin miscompares++; $display("FAIL reset_pos: got %0d, expected 0", pos); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (err_timeout !== 1'b0 || err_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_err: got tmo=%b ovf=%b, expected 0 0", err_timeout, err_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_single_inc();
    int t;
    int n;
    int fall;
    int times[8];
    apply_rst();
    resp_en = 1'b1;
    resp_lat = LAT;
    t = cyc;
    n = 0;
    fall = -1;
    for (int i = 0; i < 300; i++) begin
      ph_inc = (i == 0);
      if (i == 1) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_early: got %b, expected 1", busy); end
      end
      if (psen === 1'b1) begin
        if (n < 8) times[n] = cyc - t;
        vectors++; if (psincdec !== 1'b1) begin miscompares++; $display("FAIL single_psincdec: got %b, expected 1", psincdec); end
        n++;
      end
      if (i > 1 && busy === 1'b0) begin
        fall = cyc - t;
        break;
      end
      tick();
    end
    ph_inc = 1'b0;
    vectors++; if (n != 8) begin miscompares++; $display("FAIL single_psen_count: got %0d, expected 8", n); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (times[k] != 2 + 13 * k) begin miscompares++; $display("FAIL single_psen_time%0d: got t+%0d, expected t+%0d", k, times[k], 2 + 13 * k); end
    end
    vectors++; if (pos !== 16'sd8) begin miscompares++; $display("FAIL single_pos: got %0d, expected 8", pos); end
    vectors++; if (fall != 106) begin miscompares++; $display("FAIL single_busy_fall: got t+%0d, expected t+106", fall); end
  endtask

  task automatic test_inc_then_dec();
    int npos;
    int nneg;
    apply_rst();
    npos = 0;
    nneg = 0;
    for (int i = 0; i < 500; i++) begin
      ph_inc = (i == 0);
      ph_dec = (i == 3);
      if (psen === 1'b1) begin
        if (psincdec === 1'b1) begin
          vectors++; if (nneg != 0) begin miscompares++; $display("FAIL incdec_order: positive step after %0d negative, expected 0", nneg); end
          npos++;
        end else begin
          if (nneg == 0) begin
            vectors++; if (pos !== 16'sd8) begin miscompares++; $display("FAIL incdec_mid_pos: got %0d, expected 8", pos); end
          end
          nneg++;
        end
      end
      if (i > 1 && busy === 1'b0) break;
      tick();
    end
    ph_inc = 1'b0;
    ph_dec = 1'b0;
    vectors++; if (npos != 8 || nneg != 8) begin miscompares++; $display("FAIL incdec_counts: got +%0d/-%0d, expected +8/-8", npos, nneg); end
    vectors++; if (pos !== 16'sd0) begin miscompares++; $display("FAIL incdec_pos: got %0d, expected 0", pos); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL incdec_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_cancel();
    bit psen_seen;
    bit busy_seen;
    apply_rst();
    psen_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ph_inc = (i == 0);
      ph_dec = (i == 0);
      if (psen === 1'b1) psen_seen = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
      tick();
    end
    ph_inc = 1'b0;
    ph_dec = 1'b0;
    vectors++; if (psen_seen !== 1'b0) begin miscompares++; $display("FAIL cancel_psen: got %b, expected 0", psen_seen); end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL cancel_busy: got %b, expected 0", busy_seen); end
    vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL cancel_ovf: got %b, expected 0", err_ovf); end
  endtask

  task automatic test_overflow();
    int n;
    apply_rst();
    resp_lat = 20;
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      ph_inc = (i < 10);
      if (i == 10) resp_lat = LAT;
      if (i == 8) begin
        vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_before_sat: got %b, expected 0", err_ovf); end
      end
      if (i == 9) begin
        vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_at_sat: got %b, expected 1", err_ovf); end
      end
      if (psen === 1'b1) n++;
      if (i > 10 && busy === 1'b0) break;
      tick();
    end
    ph_inc = 1'b0;
    vectors++; if (n != 64) begin miscompares++; $display("FAIL ovf_psen_count: got %0d, expected 64", n); end
    vectors++; if (pos !== 16'sd64) begin miscompares++; $display("FAIL ovf_pos: got %0d, expected 64", pos); end
    vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b, expected 1", err_ovf); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL ovf_no_tmo: got %b, expected 0", err_timeout); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b, expected 0", err_ovf); end
  endtask

  task automatic test_timeout();
    bit psen_seen;
    apply_rst();
    resp_en = 1'b0;
    ph_inc = 1'b1;
    tick();
    ph_inc = 1'b0;
    tick();
    vectors++; if (psen !== 1'b1) begin miscompares++; $display("FAIL tmo_first_psen: got %b, expected 1", psen); end
    repeat (TMO - 1) tick();
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b, expected 0", err_timeout); end
    tick();
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_set: got %b, expected 1", err_timeout); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy_after: got %b, expected 0", busy); end
    ph_inc = 1'b1;
    tick();
    ph_inc = 1'b0;
    psen_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (psen === 1'b1) psen_seen = 1'b1;
      tick();
    end
    vectors++; if (psen_seen !== 1'b0) begin miscompares++; $display("FAIL tmo_locked: got psen %b, expected 0", psen_seen); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tmo_pending_busy: got %b, expected 1", busy); end
    resp_en = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_clr: got %b, expected 0", err_timeout); end
    vectors++; if (psen !== 1'b0) begin miscompares++; $display("FAIL tmo_clr_psen_early: got %b, expected 0", psen); end
    tick();
    vectors++; if (psen !== 1'b1 || psincdec !== 1'b1) begin miscompares++; $display("FAIL tmo_redispatch: got psen=%b incdec=%b, expected 1 1", psen, psincdec); end
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    vectors++; if (pos !== 16'sd8) begin miscompares++; $display("FAIL tmo_final_pos: got %0d, expected 8", pos); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_final_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit bad;
    apply_rst();
    resp_en = 1'b1;
    resp_lat = LAT;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ph_inc = (i == 0);
      if (pos === 16'sd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    ph_inc = 1'b0;
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rmid_reach_pos3: got %b, expected 1", found); end
    vectors++; if (psen !== 1'b1) begin miscompares++; $display("FAIL rmid_psen_at_pos3: got %b, expected 1", psen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (psen !== 1'b0 || psincdec !== 1'b0) begin miscompares++; $display("FAIL rmid_ps_out: got psen=%b incdec=%b, expected 0 0", psen, psincdec); end
    vectors++; if (pos !== 16'sd0) begin miscompares++; $display("FAIL rmid_pos: got %0d, expected 0", pos); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (psen !== 1'b0 || pos !== 16'sd0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL rmid_late_psdone: got disturbance %b, expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    ph_inc = 1'b0;
    ph_dec = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_single_inc();
    test_inc_then_dec();
    test_cancel();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
